// File: rtl/adc733_pkg.sv
// adc733_pkg: shared constants and types for the adc733 frame collector slice.
//   ADC733_NUM_CH / ADC733_DW : default channel count and sample width
//   adc733_sample_t           : one deserialized sample word
//   wr_state_t                : writer FSM states
package adc733_pkg;
  localparam int ADC733_NUM_CH = 6;
  localparam int ADC733_DW     = 16;

  typedef logic [ADC733_DW-1:0] adc733_sample_t;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    COLLECT   = 2'd1,
    DROP      = 2'd2
  } wr_state_t;
endpackage

// File: rtl/adc733_frame_bank.sv
// adc733_frame_bank: two-bank frame store with full flags.
//   clk, rst_l        : clock, async active-low reset (clears data and flags)
//   wr_en/wr_buf/wr_ch/wr_data : sample write port
//   set_full          : mark bank wr_buf full (frame complete)
//   rd_buf/rd_ch      : read select; rd_data is a pure mux of registers
//   clr_full          : mark bank rd_buf empty (frame drained)
//   full              : per-bank full flags
module adc733_frame_bank
  import adc733_pkg::*;
#(
  parameter int NUM_CH = ADC733_NUM_CH,
  parameter int DW     = ADC733_DW,
  parameter int CHW    = 3
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           wr_en,
  input  logic           wr_buf,
  input  logic [CHW-1:0] wr_ch,
  input  logic [DW-1:0]  wr_data,
  input  logic           set_full,
  input  logic           rd_buf,
  input  logic [CHW-1:0] rd_ch,
  input  logic           clr_full,
  output logic [DW-1:0]  rd_data,
  output logic [1:0]     full
);

  logic [1:0][NUM_CH-1:0][DW-1:0] mem;

  // Writer and reader never touch the same bank's flag in one cycle:
  // the writer only sets a bank it just filled, the reader only clears
  // the bank it is draining, and a bank cannot be both.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mem  <= '0;
      full <= '0;
    end else begin
      if (wr_en)    mem[wr_buf][wr_ch] <= wr_data;
      if (set_full) full[wr_buf]       <= 1'b1;
      if (clr_full) full[rd_buf]       <= 1'b0;
    end
  end

  assign rd_data = mem[rd_buf][rd_ch];

endmodule

// File: rtl/adc733_frame_collector.sv
// adc733_frame_collector: re-aligns the adc733 sample stream to SYNC,
// assembles NUM_CH-sample frames into two banks and replays them on a
// valid/ready stream.
//   clk, rst_l            : clock, async active-low reset
//   sync                  : frame-restart pulse
//   smp_data, smp_valid   : incoming samples (no backpressure)
//   out_data/out_ch/out_last/out_valid/out_ready : word stream
//   ovf, ovf_clr          : sticky whole-frame drop flag and its clear
//   aligned               : first sync seen since reset
//   out_seq (optional)    : per-frame sequence number, present when
//                           ADC733_FRAME_SEQ_EN is defined
module adc733_frame_collector
  import adc733_pkg::*;
#(
  parameter int NUM_CH = ADC733_NUM_CH,
  parameter int DW     = ADC733_DW
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          sync,
  input  logic [DW-1:0] smp_data,
  input  logic          smp_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_ch,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef ADC733_FRAME_SEQ_EN
  output logic [7:0]    out_seq,
`endif
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          aligned
);

  localparam int CHW = 3;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

  wr_state_t      state, state_n;
  logic [CHW-1:0] wr_ch, wr_ch_n, eff_ch;
  logic           wr_buf, wr_buf_n;
  logic           wr_en, set_full, ovf_set;
  logic [CHW-1:0] rd_ch;
  logic           rd_buf;
  logic [1:0]     full;
  logic           hs, rd_last, clr_full;
`ifdef ADC733_FRAME_SEQ_EN
  logic           frame_done;
  logic [7:0]     seq_cnt;
  logic [1:0][7:0] seq_bank;
`endif

  // ---------------- writer ----------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= WAIT_SYNC;
      wr_ch   <= '0;
      wr_buf  <= 1'b0;
      aligned <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state  <= state_n;
      wr_ch  <= wr_ch_n;
      wr_buf <= wr_buf_n;
      if (sync)         aligned <= 1'b1;
      if (ovf_set)      ovf     <= 1'b1;
      else if (ovf_clr) ovf     <= 1'b0;
    end
  end

  // A sync restarts the frame; a sample arriving with it is channel 0.
  assign eff_ch = sync ? '0 : wr_ch;

  always_comb begin
    state_n  = state;
    wr_ch_n  = wr_ch;
    wr_buf_n = wr_buf;
    wr_en    = 1'b0;
    set_full = 1'b0;
    ovf_set  = 1'b0;
`ifdef ADC733_FRAME_SEQ_EN
    frame_done = 1'b0;
`endif
    if (sync) begin
      state_n = COLLECT;
      wr_ch_n = '0;
    end
    if (smp_valid && (sync || state != WAIT_SYNC)) begin
      if (!sync && state == DROP) begin
        // Dropped frame: just count channels until the frame boundary.
        if (wr_ch == LAST_CH) begin
          state_n = COLLECT;
          wr_ch_n = '0;
`ifdef ADC733_FRAME_SEQ_EN
          frame_done = 1'b1;
`endif
        end else begin
          wr_ch_n = wr_ch + CHW'(1);
        end
      end else if (eff_ch == '0 && full[wr_buf]) begin
        // No free bank at frame start: drop the whole frame.
        state_n = DROP;
        wr_ch_n = CHW'(1);
        ovf_set = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (eff_ch == LAST_CH) begin
          set_full = 1'b1;
          wr_buf_n = ~wr_buf;
          wr_ch_n  = '0;
`ifdef ADC733_FRAME_SEQ_EN
          frame_done = 1'b1;
`endif
        end else begin
          wr_ch_n = eff_ch + CHW'(1);
        end
      end
    end
  end

  // ---------------- bank store ----------------
  adc733_frame_bank #(
    .NUM_CH (NUM_CH),
    .DW     (DW),
    .CHW    (CHW)
  ) u_bank (
    .clk      (clk),
    .rst_l    (rst_l),
    .wr_en    (wr_en),
    .wr_buf   (wr_buf),
    .wr_ch    (eff_ch),
    .wr_data  (smp_data),
    .set_full (set_full),
    .rd_buf   (rd_buf),
    .rd_ch    (rd_ch),
    .clr_full (clr_full),
    .rd_data  (out_data),
    .full     (full)
  );

  // ---------------- reader ----------------
  assign out_valid = full[rd_buf];
  assign out_ch    = rd_ch;
  assign rd_last   = (rd_ch == LAST_CH);
  assign out_last  = rd_last;
  assign hs        = out_valid & out_ready;
  assign clr_full  = hs & rd_last;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ch  <= '0;
      rd_buf <= 1'b0;
    end else if (hs) begin
      if (rd_last) begin
        rd_ch  <= '0;
        rd_buf <= ~rd_buf;
      end else begin
        rd_ch  <= rd_ch + CHW'(1);
      end
    end
  end

`ifdef ADC733_FRAME_SEQ_EN
  // Counts every completed frame, dropped ones included, so gaps in
  // out_seq expose drops. Aborted (sync-cut) frames do not count.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      seq_cnt  <= '0;
      seq_bank <= '0;
    end else begin
      if (frame_done) seq_cnt          <= seq_cnt + 8'd1;
      if (set_full)   seq_bank[wr_buf] <= seq_cnt;
    end
  end

  assign out_seq = seq_bank[rd_buf];
`endif

endmodule

// File: tb/tb_adc733_frame_collector.sv
module tb_adc733_frame_collector;
  import adc733_pkg::*;

  logic           clk = 1'b0;
  logic           rst_l = 1'b0;
  logic           sync = 1'b0;
  adc733_sample_t smp_data = '0;
  logic           smp_valid = 1'b0;
  adc733_sample_t out_data;
  logic [2:0]     out_ch;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           ovf;
  logic           ovf_clr = 1'b0;
  logic           aligned;
`ifdef ADC733_FRAME_SEQ_EN
  logic [7:0]     out_seq;
`endif

  int checks = 0;
  int failures = 0;

  adc733_sample_t got_d [32];
  logic [2:0]     got_c [32];
  logic           got_l [32];
  int             got_n;
  int             drain_cyc;

  always #5 clk = ~clk;

  adc733_frame_collector dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .sync      (sync),
    .smp_data  (smp_data),
    .smp_valid (smp_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ADC733_FRAME_SEQ_EN
    .out_seq   (out_seq),
`endif
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .aligned   (aligned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input adc733_sample_t d);
    smp_data  = d;
    smp_valid = 1'b1;
    step();
    smp_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  // Collect up to n words with ready held high, bounded by budget cycles.
  task automatic drain(input int n, input int budget);
    out_ready = 1'b1;
    got_n     = 0;
    drain_cyc = 0;
    while (got_n < n && drain_cyc < budget) begin
      if (out_valid) begin
        got_d[got_n] = out_data;
        got_c[got_n] = out_ch;
        got_l[got_n] = out_last;
        got_n++;
      end
      step();
      drain_cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, out_data, out_ch, out_last, ovf, aligned} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b d=%h ch=%0d last=%0b ovf=%0b al=%0b, expected all 0",
               out_valid, out_data, out_ch, out_last, ovf, aligned);
    end
    #4 rst_l = 1'b1;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 6; i++) send(16'h0BAD);
    checks++;
    if (out_valid !== 1'b0 || aligned !== 1'b0) begin
      failures++;
      $display("FAIL pre_sync: got valid=%0b aligned=%0b, expected 0 0", out_valid, aligned);
    end
    pulse_sync();
    checks++;
    if (aligned !== 1'b1) begin
      failures++;
      $display("FAIL aligned_after_sync: got %0b, expected 1", aligned);
    end
    for (int i = 0; i < 5; i++) send(16'h1000 + 16'(i));
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_early: got %0b, expected 0 after 5 samples", out_valid);
    end
    send(16'h1005);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL valid_latency: got %0b, expected 1 the cycle after the 6th sample", out_valid);
    end
    drain(6, 20);
    checks++;
    if (got_n !== 6) begin
      failures++;
      $display("FAIL basic_count: got %0d words, expected 6", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_d[i] !== 16'h1000 + 16'(i) || got_c[i] !== 3'(i) || got_l[i] !== (i == 5)) begin
        failures++;
        $display("FAIL basic_word%0d: got d=%h ch=%0d last=%0b, expected d=%h ch=%0d last=%0b",
                 i, got_d[i], got_c[i], got_l[i], 16'h1000 + 16'(i), i, (i == 5));
      end
    end
  endtask

  task automatic test_overflow();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 6; i++) begin
        // Clear arrives together with the first overflow: the set wins.
        ovf_clr = (f == 2 && i == 0);
        send(16'h3000 + 16'(f * 256 + i));
        ovf_clr = 1'b0;
      end
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got %0b, expected 1", ovf);
    end
    drain(12, 40);
    checks++;
    if (got_n !== 12 || drain_cyc !== 12) begin
      failures++;
      $display("FAIL ovf_count: got %0d words in %0d cycles, expected 12 in 12", got_n, drain_cyc);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_d[i] !== 16'h3000 + 16'((i / 6) * 256 + (i % 6)) || got_c[i] !== 3'(i % 6)) begin
        failures++;
        $display("FAIL ovf_word%0d: got d=%h ch=%0d, expected d=%h ch=%0d",
                 i, got_d[i], got_c[i], 16'h3000 + 16'((i / 6) * 256 + (i % 6)), i % 6);
      end
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_dropped_frame: got valid=%0b, expected 0", out_valid);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: got %0b, expected 0", ovf);
    end
  endtask

  task automatic test_sync_abort();
    for (int i = 0; i < 3; i++) send(16'hAAAA + 16'(i));
    pulse_sync();
    for (int i = 0; i < 6; i++) send(16'h2000 + 16'(i));
    drain(6, 20);
    checks++;
    if (got_n !== 6) begin
      failures++;
      $display("FAIL abort_count: got %0d words, expected 6", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_d[i] !== 16'h2000 + 16'(i) || got_c[i] !== 3'(i)) begin
        failures++;
        $display("FAIL abort_word%0d: got d=%h ch=%0d, expected d=%h ch=%0d",
                 i, got_d[i], got_c[i], 16'h2000 + 16'(i), i);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_extra: got valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_sync_coincident();
    send(16'hBBBB);
    send(16'hBBBC);
    sync      = 1'b1;
    smp_data  = 16'h7FFF;
    smp_valid = 1'b1;
    step();
    sync      = 1'b0;
    smp_valid = 1'b0;
    for (int i = 1; i < 6; i++) send(16'h4000 + 16'(i));
    drain(6, 20);
    checks++;
    if (got_n !== 6) begin
      failures++;
      $display("FAIL coinc_count: got %0d words, expected 6", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_d[i] !== ((i == 0) ? 16'h7FFF : 16'h4000 + 16'(i)) || got_c[i] !== 3'(i)) begin
        failures++;
        $display("FAIL coinc_word%0d: got d=%h ch=%0d, expected d=%h ch=%0d",
                 i, got_d[i], got_c[i], (i == 0) ? 16'h7FFF : 16'h4000 + 16'(i), i);
      end
    end
  endtask

  task automatic test_back_to_back();
    adc733_sample_t pd;
    logic [2:0]     pc;
    logic           pl, prev_stall, rdy;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 6; i++) send(16'h5000 + 16'(f * 256 + i));
    got_n = 0;
    prev_stall = 1'b0;
    pd = '0; pc = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 60 && got_n < 12; cyc++) begin
      rdy = cyc[0];
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_ch !== pc || out_last !== pl) begin
          failures++;
          $display("FAIL stall_stable: got v=%0b d=%h ch=%0d last=%0b, expected v=1 d=%h ch=%0d last=%0b",
                   out_valid, out_data, out_ch, out_last, pd, pc, pl);
        end
      end
      out_ready = rdy;
      if (out_valid && rdy) begin
        got_d[got_n] = out_data;
        got_c[got_n] = out_ch;
        got_n++;
      end
      prev_stall = out_valid && !rdy;
      pd = out_data; pc = out_ch; pl = out_last;
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (got_n !== 12) begin
      failures++;
      $display("FAIL toggle_count: got %0d words, expected 12", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_d[i] !== 16'h5000 + 16'((i / 6) * 256 + (i % 6)) || got_c[i] !== 3'(i % 6)) begin
        failures++;
        $display("FAIL toggle_word%0d: got d=%h ch=%0d, expected d=%h ch=%0d",
                 i, got_d[i], got_c[i], 16'h5000 + 16'((i / 6) * 256 + (i % 6)), i % 6);
      end
    end
  endtask

  task automatic test_reset_midread();
    for (int i = 0; i < 6; i++) send(16'h6000 + 16'(i));
    drain(3, 10);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_data !== 16'h6003) begin
      failures++;
      $display("FAIL midread_pos: got v=%0b ch=%0d d=%h, expected v=1 ch=3 d=6003",
               out_valid, out_ch, out_data);
    end
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_ch, out_last, ovf, aligned} !== '0) begin
      failures++;
      $display("FAIL midread_reset: got v=%0b d=%h ch=%0d last=%0b ovf=%0b al=%0b, expected all 0",
               out_valid, out_data, out_ch, out_last, ovf, aligned);
    end
    #3 rst_l = 1'b1;
    step();
    for (int i = 0; i < 6; i++) send(16'h0BAD);
    checks++;
    if (aligned !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_unaligned: got aligned=%0b valid=%0b, expected 0 0", aligned, out_valid);
    end
    pulse_sync();
    checks++;
    if (aligned !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_aligned: got %0b, expected 1", aligned);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sync_abort();
    test_sync_coincident();
    test_back_to_back();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
